// File: rtl/lsu_byteser.sv
// Byte-serial load/store unit.
// Runs one decoded load or store over an 8-bit request/acknowledge bus.
// Bytes go out little-endian, one byte per acknowledge.
// A load returns its value sign- or zero-extended.
// Every output is registered. Each output is computed from the next-state
// values, so a new value shows up in the same cycle as the FSM state it belongs to.
module lsu_byteser #(
  parameter int ADDR_W  = 32,
  parameter int ACK_TMO = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_insize,
  input  logic              i_insign,
  input  logic [2:0]        i_outsize,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [7:0]        o_bus_wdata,
  input  logic [7:0]        i_bus_rdata,
  input  logic              i_bus_ack
);

  localparam int CNT_W = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Only 0, 1, 2 and 4 are meaningful transfer sizes.
  function automatic logic size_bad(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd1, 3'd2, 3'd4: size_bad = 1'b0;
      default:                size_bad = 1'b1;
    endcase
  endfunction

  // Natural alignment: halfwords need an even address, words need a multiple of 4.
  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] lo);
    case (sz)
      3'd2:    misaligned = lo[0];
      3'd4:    misaligned = (lo != 2'd0);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Sign or zero extension of the assembled load bytes. A word is returned unchanged.
  function automatic logic [31:0] extend_load(input logic [31:0] b, input logic [2:0] sz,
                                              input logic s);
    case (sz)
      3'd1:    extend_load = {{24{s & b[7]}}, b[7:0]};
      3'd2:    extend_load = {{16{s & b[15]}}, b[15:0]};
      default: extend_load = b;
    endcase
  endfunction

  state_t              state_r, state_s;
  logic [1:0]          idx_r, idx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic [31:0]         wdata_r, wdata_s;
  logic [2:0]          size_r, size_s;
  logic                we_r, we_s;
  logic                sign_r, sign_s;
  logic [31:0]         rbuf_r, rbuf_s;
  logic                err_s;
  logic [31:0]         rdata_s;
  logic [2:0]          req_size_s;

  // Picks the request size, the FSM next state, the byte-index and timeout counters,
  // and the value o_rdata will take next.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    base_s     = base_r;
    wdata_s    = wdata_r;
    size_s     = size_r;
    we_s       = we_r;
    sign_s     = sign_r;
    rbuf_s     = rbuf_r;
    err_s      = o_err;
    rdata_s    = o_rdata;
    req_size_s = (i_insize != 3'd0) ? i_insize : i_outsize;

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          base_s  = i_addr;
          wdata_s = i_wdata;
          size_s  = req_size_s;
          we_s    = (i_outsize != 3'd0);
          sign_s  = i_insign;
          idx_s   = 2'd0;
          cnt_s   = '0;
          rbuf_s  = 32'd0;
          if (size_bad(i_insize) || size_bad(i_outsize) ||
              ((i_insize != 3'd0) && (i_outsize != 3'd0)) ||
              misaligned(req_size_s, i_addr[1:0])) begin
            state_s = ST_FIN;
            err_s   = 1'b1;
          end else if (req_size_s == 3'd0) begin
            state_s = ST_FIN;
            err_s   = 1'b0;
          end else begin
            state_s = ST_BUS;
            err_s   = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUS: begin
        if (i_bus_ack) begin
          cnt_s = '0;
          if (!we_r) begin
            rbuf_s[{idx_r, 3'b000} +: 8] = i_bus_rdata;
          end else begin
            rbuf_s = rbuf_r;
          end
          if ({1'b0, idx_r} == (size_r - 3'd1)) begin
            state_s = ST_FIN;
            err_s   = 1'b0;
            if (!we_r) begin
              rdata_s = extend_load(rbuf_s, size_r, sign_r);
            end else begin
              rdata_s = o_rdata;
            end
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else if ((ACK_TMO != 0) && (cnt_r == TMO_LAST)) begin
          state_s = ST_FIN;
          err_s   = 1'b1;
        end else if (ACK_TMO != 0) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Holds the FSM state and the access parameters latched when the access starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      cnt_r   <= '0;
      base_r  <= '0;
      wdata_r <= 32'd0;
      size_r  <= 3'd0;
      we_r    <= 1'b0;
      sign_r  <= 1'b0;
      rbuf_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      base_r  <= base_s;
      wdata_r <= wdata_s;
      size_r  <= size_s;
      we_r    <= we_s;
      sign_r  <= sign_s;
      rbuf_r  <= rbuf_s;
    end
  end

  // Output registers follow the next state, so bus signals line up with the BUS state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= 32'd0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= 8'd0;
    end else begin
      o_busy      <= (state_s != ST_IDLE);
      o_done      <= (state_s == ST_FIN);
      o_err       <= err_s;
      o_rdata     <= rdata_s;
      o_bus_req   <= (state_s == ST_BUS);
      o_bus_we    <= (state_s == ST_BUS) & we_s;
      o_bus_addr  <= base_s + ADDR_W'(idx_s);
      o_bus_wdata <= wdata_s[{idx_s, 3'b000} +: 8];
    end
  end

endmodule
